// File: rtl/deadlock_trace_sequencer.sv
// deadlock_trace_sequencer
// Central sequencer for the per-process deadlock-detect units. It picks an
// origin process and injects the trace token. It then records the chain of
// token holders until the token comes back to the origin, and streams the
// recorded cycle out over a valid/ready port.
// Optional feature: define DEADLOCK_TRACE_TIMEOUT_EN to abort a trace after
// TIMEOUT consecutive cycles with no token holder.
module deadlock_trace_sequencer #(
   parameter int PROC_NUM = 4,
   parameter int ID_W     = 2,
   parameter int TIMEOUT  = 64
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [PROC_NUM-1:0]             dl_detect_vec,
   input  logic [PROC_NUM-1:0]             token_hold_vec,
   output logic [PROC_NUM-1:0]             origin_vec,
   output logic                            token_clear,
   output logic                            dl_flag,
   input  logic                            rearm,
   output logic                            rpt_valid,
   input  logic                            rpt_ready,
   output logic [ID_W-1:0]                 rpt_proc_id,
   output logic                            rpt_last,
   output logic                            rpt_overflow,
   output logic [$clog2(PROC_NUM+1)-1:0]   trace_len
);

   localparam int CNT_W = $clog2(PROC_NUM + 1);
   localparam int IDX_W = (PROC_NUM > 1) ? $clog2(PROC_NUM) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ORIGIN = 3'd1;
   localparam logic [2:0] S_TRACE  = 3'd2;
   localparam logic [2:0] S_REPORT = 3'd3;
   localparam logic [2:0] S_CLEAR  = 3'd4;
   localparam logic [2:0] S_HALT   = 3'd5;

   // Lowest set index of a request vector (priority to process 0).
   function automatic logic [ID_W-1:0] lowest_idx(input logic [PROC_NUM-1:0] v);
      lowest_idx = '0;
      for (int p = PROC_NUM - 1; p >= 0; p--) begin
         if (v[p]) lowest_idx = ID_W'(p);
      end
   endfunction

   logic [2:0]          state_q, state_d;
   logic [ID_W-1:0]     origin_id_q, origin_id_d;
   logic [PROC_NUM-1:0] origin_vec_q, origin_vec_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [IDX_W-1:0]    rd_idx_q, rd_idx_d;
   logic                rpt_valid_q, rpt_valid_d;
   logic [ID_W-1:0]     rpt_id_q, rpt_id_d;
   logic                rpt_last_q, rpt_last_d;
   logic                overflow_q, overflow_d;
   logic                dl_flag_q, dl_flag_d;
   logic                tclr_q, tclr_d;
   logic                abort_q, abort_d;
   logic                close_now;

   logic [ID_W-1:0]     buf_q [PROC_NUM];
   logic                buf_we;
   logic [IDX_W-1:0]    buf_widx;
   logic [ID_W-1:0]     buf_wdata;

   logic [ID_W-1:0]     holder;
   logic [IDX_W-1:0]    last_idx;

   assign holder   = lowest_idx(token_hold_vec);
   assign last_idx = IDX_W'(count_q - CNT_W'(1));

`ifdef DEADLOCK_TRACE_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT + 1);
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
`else
   // Keeps TIMEOUT referenced in builds without the watchdog.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT > 0);
`endif

   // Next-state and output decode for the trace state machine.
   always_comb begin
      state_d      = state_q;
      origin_id_d  = origin_id_q;
      origin_vec_d = '0;
      count_d      = count_q;
      rd_idx_d     = rd_idx_q;
      rpt_valid_d  = rpt_valid_q;
      rpt_id_d     = rpt_id_q;
      rpt_last_d   = rpt_last_q;
      overflow_d   = overflow_q;
      dl_flag_d    = dl_flag_q;
      tclr_d       = tclr_q;
      abort_d      = abort_q;
      close_now    = 1'b0;
      buf_we       = 1'b0;
      buf_widx     = IDX_W'(count_q);
      buf_wdata    = holder;
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
      to_cnt_d     = to_cnt_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (dl_detect_vec != '0) begin
               origin_id_d  = lowest_idx(dl_detect_vec);
               origin_vec_d = PROC_NUM'(1) << lowest_idx(dl_detect_vec);
               state_d      = S_ORIGIN;
            end
         end
         S_ORIGIN: begin
            buf_we    = 1'b1;
            buf_widx  = '0;
            buf_wdata = origin_id_q;
            count_d   = CNT_W'(1);
            abort_d   = 1'b0;
            state_d   = S_TRACE;
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
            to_cnt_d  = '0;
`endif
         end
         S_TRACE: begin
            if (token_hold_vec != '0) begin
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
               to_cnt_d = '0;
`endif
               if (holder == origin_id_q || count_q == CNT_W'(PROC_NUM)) begin
                  // Loop closed (or buffer full): start streaming entry 0.
                  close_now   = (holder == origin_id_q);
                  overflow_d  = (holder != origin_id_q);
                  tclr_d      = 1'b1;
                  rd_idx_d    = '0;
                  rpt_valid_d = 1'b1;
                  rpt_id_d    = buf_q[0];
                  rpt_last_d  = (count_q == CNT_W'(1));
                  state_d     = S_REPORT;
               end else if (holder != buf_q[last_idx]) begin
                  buf_we  = 1'b1;
                  count_d = count_q + CNT_W'(1);
               end
            end
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               to_cnt_d = '0;
               abort_d  = 1'b1;
               tclr_d   = 1'b1;
               state_d  = S_CLEAR;
            end else begin
               to_cnt_d = to_cnt_q + TO_W'(1);
            end
`endif
         end
         S_REPORT: begin
            if (rpt_valid_q && rpt_ready) begin
               if (rpt_last_q) begin
                  rpt_valid_d = 1'b0;
                  rpt_last_d  = 1'b0;
                  state_d     = S_CLEAR;
               end else begin
                  rd_idx_d   = rd_idx_q + IDX_W'(1);
                  rpt_id_d   = buf_q[rd_idx_q + IDX_W'(1)];
                  rpt_last_d = (CNT_W'(rd_idx_q) + CNT_W'(2) == count_q);
               end
            end
         end
         S_CLEAR: begin
            if (abort_q) begin
               abort_d = 1'b0;
               tclr_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               dl_flag_d = 1'b1;
               state_d   = S_HALT;
            end
         end
         S_HALT: begin
            if (rearm) begin
               dl_flag_d  = 1'b0;
               overflow_d = 1'b0;
               count_d    = '0;
               tclr_d     = 1'b0;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= S_IDLE;
         origin_id_q  <= '0;
         origin_vec_q <= '0;
         count_q      <= '0;
         rd_idx_q     <= '0;
         rpt_valid_q  <= 1'b0;
         rpt_id_q     <= '0;
         rpt_last_q   <= 1'b0;
         overflow_q   <= 1'b0;
         dl_flag_q    <= 1'b0;
         tclr_q       <= 1'b0;
         abort_q      <= 1'b0;
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
         to_cnt_q     <= '0;
`endif
      end else begin
         state_q      <= state_d;
         origin_id_q  <= origin_id_d;
         origin_vec_q <= origin_vec_d;
         count_q      <= count_d;
         rd_idx_q     <= rd_idx_d;
         rpt_valid_q  <= rpt_valid_d;
         rpt_id_q     <= rpt_id_d;
         rpt_last_q   <= rpt_last_d;
         overflow_q   <= overflow_d;
         dl_flag_q    <= dl_flag_d;
         tclr_q       <= tclr_d;
         abort_q      <= abort_d;
`ifdef DEADLOCK_TRACE_TIMEOUT_EN
         to_cnt_q     <= to_cnt_d;
`endif
      end
   end

   // Trace buffer; contents are only meaningful below count_q, so no reset.
   always_ff @(posedge clock) begin
      if (buf_we) buf_q[buf_widx] <= buf_wdata;
   end

   assign origin_vec   = origin_vec_q;
   assign token_clear  = tclr_q | close_now;
   assign dl_flag      = dl_flag_q;
   assign rpt_valid    = rpt_valid_q;
   assign rpt_proc_id  = rpt_id_q;
   assign rpt_last     = rpt_last_q;
   assign rpt_overflow = overflow_q;
   assign trace_len    = count_q;

endmodule

// File: tb/tb_deadlock_trace_sequencer.sv
// Testbench for deadlock_trace_sequencer: directed scenarios plus randomized
// traces checked against a queue-based reference of the recording rules.
// The timeout scenario runs when DEADLOCK_TRACE_TIMEOUT_EN is defined.
module tb_deadlock_trace_sequencer;

   localparam int P  = 4;
   localparam int IW = 2;
   localparam int CW = 3;

   logic          clock = 1'b0;
   logic          reset;
   logic [P-1:0]  dl_detect_vec;
   logic [P-1:0]  token_hold_vec;
   logic [P-1:0]  origin_vec;
   logic          token_clear;
   logic          dl_flag;
   logic          rearm;
   logic          rpt_valid;
   logic          rpt_ready;
   logic [IW-1:0] rpt_proc_id;
   logic          rpt_last;
   logic          rpt_overflow;
   logic [CW-1:0] trace_len;

   int n_cmp = 0;
   int n_bad = 0;

   deadlock_trace_sequencer #(.PROC_NUM(P), .ID_W(IW), .TIMEOUT(8)) dut (
      .clock         (clock),
      .reset         (reset),
      .dl_detect_vec (dl_detect_vec),
      .token_hold_vec(token_hold_vec),
      .origin_vec    (origin_vec),
      .token_clear   (token_clear),
      .dl_flag       (dl_flag),
      .rearm         (rearm),
      .rpt_valid     (rpt_valid),
      .rpt_ready     (rpt_ready),
      .rpt_proc_id   (rpt_proc_id),
      .rpt_last      (rpt_last),
      .rpt_overflow  (rpt_overflow),
      .trace_len     (trace_len)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Index of lowest set bit: isolate it with v & -v, then take its log2.
   function automatic int low_idx(input logic [P-1:0] v);
      logic [P-1:0] iso;
      iso = v & (~v + 1'b1);
      return $clog2(iso);
   endfunction

   task automatic step;
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Runs one complete trace starting from an IDLE cycle whose inputs are not
   // yet driven. hv holds up to 8 holder vectors, entry i at bits [4i+3:4i].
   // mode 0: always ready, 1: random ready, 2: ready low for 3 cycles first.
   task automatic do_trace(input logic [P-1:0] det, input logic [31:0] hv,
                           input int hn, input int mode, input string tag);
      int        origin;
      int        exp_q[$];
      bit        ovf;
      int        close_at;
      int        h;
      int        n;
      int        exp_id;
      bit        done;
      logic [P-1:0] hold;

      // Reference: what the recorded chain must be.
      origin = low_idx(det);
      exp_q.push_back(origin);
      ovf = 0;
      close_at = hn - 1;
      for (int i = 0; i < hn; i++) begin
         hold = hv[4*i +: 4];
         if (hold == '0) continue;
         h = low_idx(hold);
         if (h == origin) begin close_at = i; break; end
         if (exp_q.size() == P) begin ovf = 1; close_at = i; break; end
         if (h != exp_q[exp_q.size()-1]) exp_q.push_back(h);
      end

      // IDLE cycle with detect
      dl_detect_vec = det;
      #1;
      chk({tag, "_idle_origin"}, 32'(origin_vec), 32'(0));
      // ORIGIN cycle
      step;
      dl_detect_vec = '0;
      #1;
      chk({tag, "_origin_vec"}, 32'(origin_vec), 32'(1 << origin));
      chk({tag, "_origin_tclr"}, 32'(token_clear), 32'(0));
      // TRACE cycles
      for (int i = 0; i <= close_at; i++) begin
         step;
         token_hold_vec = hv[4*i +: 4];
         dl_detect_vec  = 4'($urandom_range(0, 15));
         #1;
         chk({tag, "_trace_origin"}, 32'(origin_vec), 32'(0));
         chk({tag, "_trace_tclr"}, 32'(token_clear), 32'((i == close_at) && !ovf));
         chk({tag, "_trace_valid"}, 32'(rpt_valid), 32'(0));
      end
      // REPORT
      step;
      token_hold_vec = '0;
      dl_detect_vec  = '0;
      n = 0;
      done = 0;
      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         if (cyc > 0) step;
         case (mode)
            0:       rpt_ready = 1'b1;
            1:       rpt_ready = 1'($urandom_range(0, 1));
            default: rpt_ready = (cyc >= 3);
         endcase
         #1;
         if (cyc == 0) begin
            chk({tag, "_rpt_first_valid"}, 32'(rpt_valid), 32'(1));
            chk({tag, "_trace_len"}, 32'(trace_len), 32'(exp_q.size()));
            chk({tag, "_overflow"}, 32'(rpt_overflow), 32'(ovf));
         end
         chk({tag, "_rpt_tclr"}, 32'(token_clear), 32'(1));
         if (mode == 2 && cyc < 3) begin
            chk({tag, "_stall_valid"}, 32'(rpt_valid), 32'(1));
            chk({tag, "_stall_id"}, 32'(rpt_proc_id), 32'(exp_q[0]));
         end
         if (rpt_valid && rpt_ready) begin
            exp_id = (n < exp_q.size()) ? exp_q[n] : -1;
            $display("%s entry %0d: id=%0d last=%0d", tag, n, rpt_proc_id, rpt_last);
            chk({tag, "_entry_id"}, 32'(rpt_proc_id), 32'(exp_id));
            chk({tag, "_entry_last"}, 32'(rpt_last), 32'(n == exp_q.size() - 1));
            n++;
            done = (rpt_last === 1'b1) || (n > exp_q.size());
         end
      end
      chk({tag, "_entry_count"}, 32'(n), 32'(exp_q.size()));
      // CLEAR
      step;
      rpt_ready = 1'b0;
      #1;
      chk({tag, "_clear_valid"}, 32'(rpt_valid), 32'(0));
      chk({tag, "_clear_flag"}, 32'(dl_flag), 32'(0));
      chk({tag, "_clear_tclr"}, 32'(token_clear), 32'(1));
      // HALT
      step;
      #1;
      chk({tag, "_halt_flag"}, 32'(dl_flag), 32'(1));
      chk({tag, "_halt_len"}, 32'(trace_len), 32'(exp_q.size()));
      chk({tag, "_halt_ovf"}, 32'(rpt_overflow), 32'(ovf));
      for (int k = 0; k < 2; k++) begin
         step;
         dl_detect_vec  = 4'($urandom_range(1, 15));
         token_hold_vec = 4'($urandom_range(0, 15));
         #1;
         chk({tag, "_halt_origin"}, 32'(origin_vec), 32'(0));
         chk({tag, "_halt_flag_hold"}, 32'(dl_flag), 32'(1));
         chk({tag, "_halt_tclr"}, 32'(token_clear), 32'(1));
      end
      // rearm
      step;
      dl_detect_vec  = '0;
      token_hold_vec = '0;
      rearm = 1'b1;
      #1;
      chk({tag, "_prearm_flag"}, 32'(dl_flag), 32'(1));
      step;
      rearm = 1'b0;
      #1;
      chk({tag, "_rearm_flag"}, 32'(dl_flag), 32'(0));
      chk({tag, "_rearm_ovf"}, 32'(rpt_overflow), 32'(0));
      chk({tag, "_rearm_len"}, 32'(trace_len), 32'(0));
      chk({tag, "_rearm_tclr"}, 32'(token_clear), 32'(0));
   endtask

   initial begin
      logic [P-1:0] det;
      logic [31:0]  hv;
      logic [P-1:0] v;
      int           org;
      int           hn;

      reset = 1'b1;
      dl_detect_vec = '0;
      token_hold_vec = '0;
      rearm = 1'b0;
      rpt_ready = 1'b0;
      step;
      step;
      chk("reset_origin", 32'(origin_vec), 32'(0));
      chk("reset_tclr", 32'(token_clear), 32'(0));
      chk("reset_flag", 32'(dl_flag), 32'(0));
      chk("reset_valid", 32'(rpt_valid), 32'(0));
      chk("reset_last", 32'(rpt_last), 32'(0));
      chk("reset_ovf", 32'(rpt_overflow), 32'(0));
      chk("reset_len", 32'(trace_len), 32'(0));
      chk("reset_id", 32'(rpt_proc_id), 32'(0));
      step;
      reset = 1'b0;
      #1;

      // Basic loop: origin 2, holders 0, 3, 2 -> stream 2,0,3
      do_trace(4'b0100, {20'h0, 4'b0100, 4'b1000, 4'b0001}, 3, 0, "basic");
      // Same loop with 3 cycles of backpressure on entry 0
      do_trace(4'b0100, {20'h0, 4'b0100, 4'b1000, 4'b0001}, 3, 2, "bpress");
      // Simultaneous detects and multi-hot holder -> 1,2
      do_trace(4'b1010, {24'h0, 4'b0010, 4'b1100}, 2, 0, "simul");
      // Overflow: origin 0, holders 1,2,3,1 -> 0,1,2,3
      do_trace(4'b0001, {16'h0, 4'b0010, 4'b1000, 4'b0100, 4'b0010}, 4, 0, "ovfl");
      // Repeated holder and idle gaps recorded once -> 0,1,2
      do_trace(4'b0001, {12'h0, 4'b0001, 4'b0100, 4'b0000, 4'b0010, 4'b0010}, 5, 1, "repeat");

      // Reset in the middle of a trace
      dl_detect_vec = 4'b1000;
      #1;
      step;
      dl_detect_vec = '0;
      #1;
      chk("rst_mid_origin", 32'(origin_vec), 32'(4'b1000));
      step;
      token_hold_vec = 4'b0001;
      #1;
      step;
      token_hold_vec = '0;
      reset = 1'b1;
      #1;
      step;
      #1;
      chk("rst_mid_origin0", 32'(origin_vec), 32'(0));
      chk("rst_mid_tclr", 32'(token_clear), 32'(0));
      chk("rst_mid_valid", 32'(rpt_valid), 32'(0));
      chk("rst_mid_len", 32'(trace_len), 32'(0));
      chk("rst_mid_flag", 32'(dl_flag), 32'(0));
      step;
      reset = 1'b0;
      #1;
      chk("rst_post_valid", 32'(rpt_valid), 32'(0));
      chk("rst_post_tclr", 32'(token_clear), 32'(0));
      step;
      #1;
      chk("rst_idle_valid", 32'(rpt_valid), 32'(0));
      chk("rst_idle_origin", 32'(origin_vec), 32'(0));

`ifdef DEADLOCK_TRACE_TIMEOUT_EN
      // Timeout: origin 1, no holders -> CLEAR 8 cycles after TRACE entry
      dl_detect_vec = 4'b0010;
      #1;
      step;
      dl_detect_vec = '0;
      #1;
      chk("to_origin", 32'(origin_vec), 32'(4'b0010));
      for (int k = 0; k < 8; k++) begin
         step;
         #1;
         chk("to_wait_tclr", 32'(token_clear), 32'(0));
         chk("to_wait_valid", 32'(rpt_valid), 32'(0));
      end
      step;
      #1;
      chk("to_clear_tclr", 32'(token_clear), 32'(1));
      chk("to_clear_valid", 32'(rpt_valid), 32'(0));
      step;
      #1;
      chk("to_idle_tclr", 32'(token_clear), 32'(0));
      chk("to_idle_flag", 32'(dl_flag), 32'(0));
      chk("to_idle_valid", 32'(rpt_valid), 32'(0));
`endif

      // Randomized traces
      for (int t = 0; t < 25; t++) begin
         det = 4'($urandom_range(1, 15));
         org = low_idx(det);
         hn  = $urandom_range(0, 6);
         hv  = '0;
         for (int i = 0; i < hn; i++) begin
            v = 4'($urandom_range(0, 15)) & ~(4'(1) << org);
            hv[4*i +: 4] = v;
         end
         v = (4'($urandom_range(0, 15)) & ~((4'(1) << (org + 1)) - 4'(1))) | (4'(1) << org);
         hv[4*hn +: 4] = v;
         do_trace(det, hv, hn + 1, 1, $sformatf("rnd%0d", t));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
